// File: rtl/dual_clock_fifo_pkg.sv
// dual_clock_fifo_pkg
//   Shared defaults for the single-clock FIFO (dual_clock_fifo) and its
//   storage array. Holds the default word width, the default depth and
//   the word type.
package dual_clock_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/dual_clock_fifo_mem.sv
// dual_clock_fifo_mem
//   DEPTH x DATA_WIDTH register array with a synchronous write port and
//   a synchronous, registered read port. The contents are not reset.
//   rdata holds its value in every cycle where re is low.
// Ports:
//   clk1  - clock
//   we    - write enable; wdata is stored at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   re    - read enable; mem[raddr] is loaded into rdata on the rising edge
//   raddr - read address
//   rdata - registered read data
module dual_clock_fifo_mem
  import dual_clock_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk1,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // When the FIFO is full, a simultaneous read and write hit the same
  // address. The non-blocking read returns the old (oldest) word, which
  // is the FIFO ordering we want.
  always_ff @(posedge clk1) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dual_clock_fifo.sv
// dual_clock_fifo
//   Single-clock synchronous FIFO. The name is historical; there is only
//   one clock domain (clk1). Reset is synchronous and active-low.
// Ports:
//   clk1     - sole clock
//   reset_n  - synchronous active-low reset
//   data_in  - write data
//   write_en - write request; accepted when not full or when reading too
//   read_en  - read request; accepted when not empty
//   data_out - registered read data; holds when no read is accepted
//   full     - DEPTH words stored
//   empty    - no words stored
//   overflow, underflow - sticky error flags, present only when
//                         DUAL_CLOCK_FIFO_ERR_EN is defined
module dual_clock_fifo
  import dual_clock_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk1,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
`ifdef DUAL_CLOCK_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic                  dout_clr_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                 (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

  assign wr_acc = write_en && (!full || read_en);
  assign rd_acc = read_en && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
  end

  // The array has no reset, so data_out is forced to zero from reset
  // until the first accepted read reloads the array's read register.
  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      dout_clr_q <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (rd_acc) dout_clr_q <= 1'b0;
    end
  end

  dual_clock_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk1 (clk1),
    .we   (wr_acc && reset_n),
    .waddr(wptr_q[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .re   (rd_acc && reset_n),
    .raddr(rptr_q[ADDR_WIDTH-1:0]),
    .rdata(mem_rdata)
  );

  assign data_out = dout_clr_q ? '0 : mem_rdata;

`ifdef DUAL_CLOCK_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk1) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write_en && full && !read_en) overflow_q  <= 1'b1;
      if (read_en && empty)             underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_dual_clock_fifo.sv
module tb_dual_clock_fifo;
  import dual_clock_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk1 = 1'b0;
  logic       reset_n = 1'b0;
  fifo_word_t data_in = '0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  fifo_word_t data_out;
  logic       full, empty;
`ifdef DUAL_CLOCK_FIFO_ERR_EN
  logic       overflow, underflow;
`endif

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk1 = ~clk1;

  dual_clock_fifo dut (
    .clk1    (clk1),
    .reset_n (reset_n),
    .data_in (data_in),
    .write_en(write_en),
    .read_en (read_en),
    .data_out(data_out),
    .full    (full),
`ifdef DUAL_CLOCK_FIFO_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .empty   (empty)
  );

  // Behavioural model: a queue of stored words plus the last word read.
  fifo_word_t q[$];
  fifo_word_t exp_dout = '0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  always @(posedge clk1) begin
    if (!reset_n) begin
      q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      if (write_en && q.size() == DEPTH && !read_en) exp_ovf = 1'b1;
      if (read_en && q.size() == 0) exp_unf = 1'b1;
      if (read_en && q.size() > 0) begin
        exp_dout = q.pop_front();
        if (write_en) q.push_back(data_in);
      end else if (write_en && q.size() < DEPTH) begin
        q.push_back(data_in);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk1) begin
    if (chk_en) begin
      check("model_empty", 32'(empty), 32'(q.size() == 0));
      check("model_full", 32'(full), 32'(q.size() == DEPTH));
      check("model_dout", 32'(data_out), 32'(exp_dout));
`ifdef DUAL_CLOCK_FIFO_ERR_EN
      check("model_ovf", 32'(overflow), 32'(exp_ovf));
      check("model_unf", 32'(underflow), 32'(exp_unf));
`endif
    end
  end

  // Drive one cycle of inputs; the following rising edge applies them.
  task automatic cyc(input logic w, input logic r, input fifo_word_t d, input logic rst_n);
    @(negedge clk1);
    write_en = w;
    read_en  = r;
    data_in  = d;
    reset_n  = rst_n;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    idle();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(data_out), 32'h00);
    chk_en = 1'b1;

    // Single word
    cyc(1'b1, 1'b0, 8'hAA, 1'b1);
    idle();
    check("single_not_empty", 32'(empty), 32'd0);
    idle();
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    idle();
    check("single_dout", 32'(data_out), 32'hAA);
    check("single_empty", 32'(empty), 32'd1);

    // Fill and drain
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b1);
    idle();
    check("fill_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 8'hFF, 1'b1);
    idle();
    check("drop_full", 32'(full), 32'd1);
`ifdef DUAL_CLOCK_FIFO_ERR_EN
    check("overflow_set", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b1);
      idle();
      check("drain_dout", 32'(data_out), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
    cyc(1'b1, 1'b1, 8'h55, 1'b1);
    idle();
    check("simul_full", 32'(full), 32'd1);
    check("simul_oldest", 32'(data_out), 32'h10);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, 1'b1);
    idle();
    check("simul_last", 32'(data_out), 32'h55);
    check("simul_empty", 32'(empty), 32'd1);

    // Empty read leaves data_out alone
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    idle();
    check("empty_read_dout", 32'(data_out), 32'h55);
`ifdef DUAL_CLOCK_FIFO_ERR_EN
    check("underflow_set", 32'(underflow), 32'd1);
`endif

    // Read and write together while empty: only the write lands
    cyc(1'b1, 1'b1, 8'h77, 1'b1);
    idle();
    check("rw_empty_dout", 32'(data_out), 32'h55);
    check("rw_empty_notempty", 32'(empty), 32'd0);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    idle();
    check("rw_empty_read", 32'(data_out), 32'h77);

    // Interleaved pairs across pointer wrap
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b1);
      cyc(1'b0, 1'b1, 8'h00, 1'b1);
    end
    idle();
    check("wrap_last", 32'(data_out), 32'hA7);
    check("wrap_empty", 32'(empty), 32'd1);

    // Mid-operation reset with requests in the reset cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
    cyc(1'b1, 1'b1, 8'h99, 1'b0);
    idle();
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_dout", 32'(data_out), 32'h00);
`ifdef DUAL_CLOCK_FIFO_ERR_EN
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_unf", 32'(underflow), 32'd0);
`endif
    cyc(1'b1, 1'b0, 8'h3C, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    idle();
    check("post_rst_dout", 32'(data_out), 32'h3C);
    check("post_rst_empty", 32'(empty), 32'd1);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
